instr_mem_loader: RTL and testbench
===================================

# instr_mem_loader

Program loader on the write side of the instruction memory: accepts a byte stream over a valid/ready handshake, packs little-endian bytes into 32-bit words and writes them to consecutive instruction-memory word addresses. While loading, it holds the core in reset through `core_hold`. It is the writer counterpart to the core's instruction fetch, which reads that memory.

## Interface
- `DEPTH_WORDS`, 64: instruction-memory capacity in 32-bit words.
- `AW`, 8: byte-address width of `IM_A`, which must cover `4*DEPTH_WORDS`.
- `CLK` input 1: single clock, rising edge.
- `Reset` input 1: asynchronous, active-high reset.
- `start` input 1: one-cycle request to begin a load.
- `byte_valid` input 1: `byte_data` is valid.
- `byte_data` input 8: stream byte.
- `byte_ready` output 1: loader accepts a byte this cycle.
- `IM_WE` output 1: instruction-memory write enable, one-cycle pulse.
- `IM_A` output AW: byte address of the write, word aligned (bits [1:0]=0).
- `IM_WD` output 32: write data.
- `core_hold` output 1: keep the core in reset.
- `done` output 1: load completed successfully.
- `err` output 1: word count exceeded `DEPTH_WORDS`.

## Operation
- Stream format:
  - 2 header bytes: word count N, 16-bit little-endian (low byte first).
  - Then 4*N payload bytes; each word is little-endian (first byte goes to [7:0]).
- A byte transfers on a rising edge where `byte_valid` and `byte_ready` are both 1.
- FSM states and transitions:
  - IDLE: leaves on `start` to LEN_LO.
  - LEN_LO: on a byte, goes to LEN_HI.
  - LEN_HI: on a byte:
    - N==0 goes to DONE.
    - N>`DEPTH_WORDS` goes to ERR.
    - Otherwise goes to DATA.
  - DATA: goes to WRITE on the 4th byte of a word.
  - WRITE: goes back to DATA if words remain, otherwise to DONE.
  - DONE and ERR: go to LEN_LO on `start`.
- `byte_ready`=1 only in LEN_LO, LEN_HI and DATA.
- `core_hold`=1 in LEN_LO, LEN_HI, DATA, WRITE and ERR; 0 in IDLE and DONE.
- Each load writes from `IM_A`=0.
  - `IM_A` steps by 4 after each write.
  - A 2-bit byte index selects the byte lane; it wraps 3→0 on the 4th byte.
- `start` is ignored in LEN_LO, LEN_HI, DATA and WRITE.
- `done` and `err` are levels. They hold until the next accepted `start`, which clears them.
- Bytes offered in IDLE, WRITE, DONE or ERR are not accepted.

## Timing
- Reset values:
  - State IDLE.
  - `byte_ready`, `IM_WE`, `core_hold`, `done`, `err` all 0.
  - `IM_A`=0, `IM_WD`=0.
  - Word counters and byte index 0.
- Reset mid-load aborts immediately. Words already written stay in memory, and the next `start` restarts from address 0.
- After `start` is sampled, `byte_ready`=1 and `core_hold`=1 from the next cycle.
- Write latency: the 4th byte accepted at edge k gives `IM_WE`=1 with stable `IM_A`/`IM_WD` during cycle k+1 (WRITE state). The memory captures at edge k+1.
- `byte_ready`=0 during WRITE, so each word costs at least 5 cycles.
- After the last write, `done`=1 and `core_hold`=0 from the cycle after WRITE. The core therefore leaves reset no earlier than that.
- Word-count boundaries:
  - N==`DEPTH_WORDS` is legal; the last word goes to 4*(`DEPTH_WORDS`-1).
  - N==`DEPTH_WORDS`+1 raises `err`, one cycle after the high header byte.
- Valid/ready rules:
  - `byte_valid` may stay high across WRITE; that byte is taken in the next DATA cycle.
  - `byte_valid` gaps may occur at any point; state holds.

## Structure
- Package `loader_pkg`:
  - FSM state enum: IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR.
  - `BYTES_PER_WORD`=4.
  - `HDR_BYTES`=2.
- Sub-module `word_packer`:
  - Shift/lane register holding the byte index.
  - Outputs the packed 32-bit word and a `word_full` pulse.
  - Cleared by `Reset` and by `start`.
- Top level holds the FSM, the word-count and remaining-word counters, and the address register.

## Test plan
- Basic load: header 0x02,0x00, then bytes 13 05 00 00 93 00 10 00 -> `IM_WE` pulses at `IM_A`=0 (`IM_WD`=0x00000513) and at `IM_A`=4 (0x00100093); then `done`=1 and `core_hold`=0.
- Zero length: header 0x00,0x00 -> no `IM_WE`, `done`=1 one cycle after the second byte, `err`=0.
- Overflow: header 0x41,0x00 with `DEPTH_WORDS`=64 -> `err`=1, `byte_ready`=0, `core_hold`=1, no writes; a following `start` clears `err`.
- Stalls: random `byte_valid` gaps and `byte_valid` held high through WRITE -> identical write sequence to the basic test; no byte lost or duplicated.
- Reset mid-load: assert `Reset` after 5 payload bytes -> all outputs return to reset values asynchronously; a new load of N=1 writes 0xDEADBEEF at `IM_A`=0.
- Full depth: N=64 with word i = i -> last write at `IM_A`=0xFC with data 0x3F; `start` during the load is ignored.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// Imported by the loader top level and its byte-packing sub-module.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_BYTES      = 2;

  // The core stays in reset whenever the loader owns the memory or failed.
  function automatic logic holds_core(state_e s);
    return (s != IDLE) && (s != DONE);
  endfunction

endpackage

// File: rtl/word_packer.sv
// Collects little-endian stream bytes into 32-bit words.
// word is valid combinationally on the cycle word_full pulses.
module word_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0]  idx_q, idx_d;
  logic [23:0] sh_q, sh_d;

  // Older bytes drift toward bit 0, so the first byte lands in [7:0].
  assign word      = {din, sh_q};
  assign word_full = en && (idx_q == 2'(BYTES_PER_WORD - 1));

  always_comb begin
    idx_d = idx_q;
    sh_d  = sh_q;
    if (clr) begin
      idx_d = '0;
      sh_d  = '0;
    end else if (en) begin
      idx_d = idx_q + 2'd1;
      sh_d  = {din, sh_q[23:8]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      sh_q  <= '0;
    end else begin
      idx_q <= idx_d;
      sh_q  <= sh_d;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Streams a length-prefixed program into instruction memory
// while holding the core in reset.
module instr_mem_loader
  import loader_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int AW          = 8
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          start,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  output logic          IM_WE,
  output logic [AW-1:0] IM_A,
  output logic [31:0]   IM_WD,
  output logic          core_hold,
  output logic          done,
  output logic          err
);

  state_e        state_q, state_d;
  logic [7:0]    len_lo_q, len_lo_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   rem_q, rem_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wd_q, wd_d;
  logic          rdy_q, rdy_d;
  logic          we_q, we_d;
  logic          hold_q, hold_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic        accept;
  logic        start_acc;
  logic        pk_en;
  logic [31:0] pk_word;
  logic        pk_full;
  logic [15:0] n_hdr;

  assign accept    = byte_valid && rdy_q;
  assign start_acc = start &&
                     (state_q == IDLE || state_q == DONE || state_q == ERR);
  assign pk_en     = accept && (state_q == DATA);
  assign n_hdr     = {byte_data, len_lo_q};

  word_packer u_packer (
    .clk       (CLK),
    .rst       (Reset),
    .clr       (start_acc),
    .en        (pk_en),
    .din       (byte_data),
    .word      (pk_word),
    .word_full (pk_full)
  );

  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    addr_d   = addr_q;
    wd_d     = wd_q;
    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = LEN_LO;
          cnt_d   = '0;
          rem_d   = '0;
          addr_d  = '0;
        end
      end
      LEN_LO: begin
        if (accept) begin
          len_lo_d = byte_data;
          state_d  = LEN_HI;
        end
      end
      LEN_HI: begin
        if (accept) begin
          cnt_d = n_hdr;
          rem_d = n_hdr;
          if (n_hdr == 16'd0) begin
            state_d = DONE;
          end else if (n_hdr > 16'(DEPTH_WORDS)) begin
            state_d = ERR;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (pk_full) begin
          wd_d    = pk_word;
          state_d = WRITE;
        end
      end
      WRITE: begin
        addr_d  = addr_q + AW'(BYTES_PER_WORD);
        rem_d   = rem_q - 16'd1;
        state_d = (rem_q == 16'd1) ? DONE : DATA;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are flop-driven.
  always_comb begin
    rdy_d  = (state_d == LEN_LO) || (state_d == LEN_HI) ||
             (state_d == DATA);
    we_d   = (state_d == WRITE);
    hold_d = holds_core(state_d);
    done_d = (state_d == DONE);
    err_d  = (state_d == ERR);
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      len_lo_q <= '0;
      cnt_q    <= '0;
      rem_q    <= '0;
      addr_q   <= '0;
      wd_q     <= '0;
      rdy_q    <= 1'b0;
      we_q     <= 1'b0;
      hold_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_lo_q <= len_lo_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      addr_q   <= addr_d;
      wd_q     <= wd_d;
      rdy_q    <= rdy_d;
      we_q     <= we_d;
      hold_q   <= hold_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign byte_ready = rdy_q;
  assign IM_WE      = we_q;
  assign IM_A       = addr_q;
  assign IM_WD      = wd_q;
  assign core_hold  = hold_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized bench for instr_mem_loader against a stream-level
// model of the expected instruction-memory writes.
module tb_instr_mem_loader;

  logic       CLK = 1'b0;
  logic       Reset;
  logic       start;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;
  logic       IM_WE;
  logic [7:0] IM_A;
  logic [31:0] IM_WD;
  logic       core_hold;
  logic       done;
  logic       err;

  int errs = 0;
  int checks = 0;
  bit gap_en = 0;

  logic [7:0]  pl[$];
  logic [31:0] ea[$];
  logic [31:0] ed[$];

  instr_mem_loader #(.DEPTH_WORDS(64), .AW(8)) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .IM_WE      (IM_WE),
    .IM_A       (IM_A),
    .IM_WD      (IM_WD),
    .core_hold  (core_hold),
    .done       (done),
    .err        (err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Every observed write must be the next one the stream implies.
  always @(negedge CLK) begin
    if (!Reset && IM_WE) begin
      if (ea.size() == 0) chk("unexp_we", 1, 0);
      else begin
        chk("im_a", {24'd0, IM_A}, ea.pop_front());
        chk("im_wd", IM_WD, ed.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_rdy", byte_ready, 1);
    chk("start_hold", core_hold, 1);
    chk("start_done", done, 0);
    chk("start_err", err, 0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic r;
    r = 1'b0;
    if (gap_en) begin
      repeat ($urandom_range(0, 2)) begin
        byte_valid = 1'b0;
        tick();
      end
    end
    byte_valid = 1'b1;
    byte_data  = b;
    for (int t = 0; t < 20 && !r; t++) begin
      @(negedge CLK);
      r = byte_ready;
      tick();
    end
    if (!r) chk("byte_timeout", 0, 1);
  endtask

  // Model: word i = payload bytes 4i..4i+3 little-endian, at byte addr 4i.
  task automatic run_load(input int n, input int start_at);
    for (int i = 0; i < n; i++) begin
      ea.push_back(32'(4 * i));
      ed.push_back({pl[4*i+3], pl[4*i+2], pl[4*i+1], pl[4*i]});
    end
    pulse_start();
    send_byte(8'(n));
    send_byte(8'(n >> 8));
    for (int i = 0; i < pl.size(); i++) begin
      if (i == start_at) begin
        byte_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ign_start_hold", core_hold, 1);
        chk("ign_start_done", done, 0);
      end
      send_byte(pl[i]);
    end
    byte_valid = 1'b0;
    if (n == 0) begin
      chk("zero_done", done, 1);
      chk("zero_hold", core_hold, 0);
    end else begin
      chk("wr_hold", core_hold, 1);
      chk("wr_done", done, 0);
      tick();
      chk("end_done", done, 1);
      chk("end_hold", core_hold, 0);
      chk("end_rdy", byte_ready, 0);
    end
    chk("end_err", err, 0);
    chk("drain", ea.size(), 0);
  endtask

  task automatic rand_payload(input int n);
    pl.delete();
    for (int i = 0; i < 4 * n; i++) pl.push_back(8'($urandom));
  endtask

  initial begin
    logic r;
    Reset = 1'b1;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    #3;
    chk("rst_rdy", byte_ready, 0);
    chk("rst_we", IM_WE, 0);
    chk("rst_hold", core_hold, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_a", {24'd0, IM_A}, 0);
    chk("rst_wd", IM_WD, 0);
    @(negedge CLK);
    Reset = 1'b0;
    tick();

    // basic load
    pl = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_load(2, -1);

    // zero length
    pl.delete();
    run_load(0, -1);

    // overflow
    pulse_start();
    send_byte(8'h41);
    send_byte(8'h00);
    byte_valid = 1'b0;
    chk("ovf_err", err, 1);
    chk("ovf_rdy", byte_ready, 0);
    chk("ovf_hold", core_hold, 1);
    chk("ovf_done", done, 0);
    byte_valid = 1'b1;
    byte_data = 8'h55;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      r = byte_ready;
      chk("ovf_no_accept", r, 0);
      tick();
    end
    byte_valid = 1'b0;
    pl.delete();
    run_load(0, -1);

    // stalls, same stream as the basic load
    gap_en = 1;
    pl = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_load(2, -1);

    // random loads with gaps
    for (int k = 0; k < 4; k++) begin
      int n;
      n = $urandom_range(1, 6);
      rand_payload(n);
      run_load(n, -1);
    end
    gap_en = 0;

    // reset mid-load after 5 payload bytes
    pulse_start();
    send_byte(8'h03);
    send_byte(8'h00);
    ea.push_back(0);
    ed.push_back(32'h44332211);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    byte_valid = 1'b0;
    chk("mid_drain", ea.size(), 0);
    Reset = 1'b1;
    #1;
    chk("mid_rdy", byte_ready, 0);
    chk("mid_we", IM_WE, 0);
    chk("mid_hold", core_hold, 0);
    chk("mid_done", done, 0);
    chk("mid_a", {24'd0, IM_A}, 0);
    chk("mid_wd", IM_WD, 0);
    @(negedge CLK);
    Reset = 1'b0;
    tick();
    pl = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_load(1, -1);

    // full depth, word i = i, start pulsed mid-load
    pl.delete();
    for (int i = 0; i < 64; i++) begin
      pl.push_back(8'(i));
      pl.push_back(8'h00);
      pl.push_back(8'h00);
      pl.push_back(8'h00);
    end
    run_load(64, 41);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
